// File: rtl/binary_result_buffer_pkg.sv
// Shared constants and readout FSM encoding for the binary result frame store.
package binary_result_buffer_pkg;

    localparam int unsigned WIDTH_BITS  = 8;
    localparam int unsigned HEIGHT_BITS = 8;
    localparam int unsigned NUM_PIXELS  = 2 ** (WIDTH_BITS + HEIGHT_BITS);
    localparam int unsigned CNT_BITS    = WIDTH_BITS + HEIGHT_BITS + 1;

    typedef enum logic [2:0] {
        ST_CAPTURE,
        ST_ISSUE,
        ST_WAIT,
        ST_SHOW,
        ST_DONE
    } state_t;

endpackage

// File: rtl/binary_result_buffer_ram.sv
// Simple dual-port 1-bit frame RAM: synchronous write, registered read (1-cycle latency).
module result_bit_ram
    import binary_result_buffer_pkg::*;
#(
    parameter int unsigned ADDR_BITS = WIDTH_BITS + HEIGHT_BITS
) (
    input  logic                 clock,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic                 wr_data_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic                 rd_data_o
);

    logic mem_q [0:(2**ADDR_BITS)-1];
    logic rd_data_q;

    // No reset on the array or read register so the store maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/binary_result_buffer.sv
// Captures the binarised pixel stream into a frame store, counts writes/ones,
// and on iStart streams the frame out in raster order over valid/ready.
module binary_result_buffer #(
    parameter int unsigned WIDTH_BITS  = binary_result_buffer_pkg::WIDTH_BITS,
    parameter int unsigned HEIGHT_BITS = binary_result_buffer_pkg::HEIGHT_BITS
) (
    input  logic                              clock,
    input  logic                              not_reset,
    input  logic [HEIGHT_BITS-1:0]            iX,
    input  logic [WIDTH_BITS-1:0]             iY,
    input  logic                              iValue,
    input  logic                              iWren,
    input  logic                              iStart,
    output logic                              oPixValid,
    input  logic                              iPixReady,
    output logic [HEIGHT_BITS-1:0]            oPixX,
    output logic [WIDTH_BITS-1:0]             oPixY,
    output logic                              oPixData,
    output logic                              oFrameLast,
    output logic [WIDTH_BITS+HEIGHT_BITS:0]   oWriteCount,
    output logic [WIDTH_BITS+HEIGHT_BITS:0]   oOnesCount,
    output logic                              oBusy,
    output logic                              oDone,
    output logic                              oOverrun
);

    import binary_result_buffer_pkg::*;

    localparam int unsigned ADDR_BITS = WIDTH_BITS + HEIGHT_BITS;
    localparam int unsigned CNT_W     = ADDR_BITS + 1;
    localparam logic [CNT_W-1:0]     CNT_MAX   = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]       ones_cnt_q, ones_cnt_d;
    logic                   valid_q, valid_d;
    logic [HEIGHT_BITS-1:0] pix_x_q, pix_x_d;
    logic [WIDTH_BITS-1:0]  pix_y_q, pix_y_d;
    logic                   pix_data_q, pix_data_d;
    logic                   last_q, last_d;
    logic                   overrun_q, overrun_d;

    logic accept;
    logic transfer;
    logic rd_data;

    assign accept   = iWren && (state_q == ST_CAPTURE);
    assign transfer = (state_q == ST_SHOW) && valid_q && iPixReady;

    result_bit_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clock     (clock),
        .wr_en_i   (accept),
        .wr_addr_i ({iX, iY}),
        .wr_data_i (iValue),
        .rd_addr_i (ptr_q),
        .rd_data_o (rd_data)
    );

    // State register and all sequential datapath state.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state_q    <= ST_CAPTURE;
            ptr_q      <= '0;
            wr_cnt_q   <= '0;
            ones_cnt_q <= '0;
            valid_q    <= 1'b0;
            pix_x_q    <= '0;
            pix_y_q    <= '0;
            pix_data_q <= 1'b0;
            last_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wr_cnt_q   <= wr_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            valid_q    <= valid_d;
            pix_x_q    <= pix_x_d;
            pix_y_q    <= pix_y_d;
            pix_data_q <= pix_data_d;
            last_q     <= last_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state and read pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CAPTURE: begin
                if (iStart) begin
                    state_d = ST_ISSUE;
                    ptr_d   = '0;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_SHOW;
            ST_SHOW: begin
                if (transfer) begin
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        ptr_d   = ptr_q + 1'b1;
                    end
                end
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_CAPTURE;
        endcase
    end

    // Outputs: readout pixel register, counters and status flags.
    always_comb begin
        valid_d    = valid_q;
        pix_x_d    = pix_x_q;
        pix_y_d    = pix_y_q;
        pix_data_d = pix_data_q;
        last_d     = last_q;
        wr_cnt_d   = wr_cnt_q;
        ones_cnt_d = ones_cnt_q;
        overrun_d  = overrun_q | (iWren && (state_q != ST_CAPTURE));
        oBusy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_SHOW);
        oDone      = (state_q == ST_DONE);

        // Write is counted in the same cycle a start pulse moves us out of CAPTURE.
        if (accept) begin
            if (wr_cnt_q != CNT_MAX) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
            if (iValue && (ones_cnt_q != CNT_MAX)) begin
                ones_cnt_d = ones_cnt_q + 1'b1;
            end
        end

        if (state_q == ST_WAIT) begin
            valid_d              = 1'b1;
            pix_data_d           = rd_data;
            {pix_x_d, pix_y_d}   = ptr_q;
            last_d               = (ptr_q == LAST_ADDR);
        end else if (transfer) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    assign oPixValid   = valid_q;
    assign oPixX       = pix_x_q;
    assign oPixY       = pix_y_q;
    assign oPixData    = pix_data_q;
    assign oFrameLast  = last_q;
    assign oWriteCount = wr_cnt_q;
    assign oOnesCount  = ones_cnt_q;
    assign oOverrun    = overrun_q;

endmodule

// File: tb/tb_binary_result_buffer.sv
// Self-checking bench for binary_result_buffer against an array/count reference model.
module tb_binary_result_buffer;

    localparam int W  = 6;
    localparam int H  = 6;
    localparam int A  = W + H;
    localparam int N  = 2 ** A;
    localparam int CB = A + 1;

    logic          clock = 1'b0;
    logic          not_reset;
    logic [H-1:0]  iX;
    logic [W-1:0]  iY;
    logic          iValue, iWren, iStart, iPixReady;
    logic          oPixValid, oPixData, oFrameLast, oBusy, oDone, oOverrun;
    logic [H-1:0]  oPixX;
    logic [W-1:0]  oPixY;
    logic [CB-1:0] oWriteCount, oOnesCount;

    binary_result_buffer #(
        .WIDTH_BITS  (W),
        .HEIGHT_BITS (H)
    ) dut (
        .clock       (clock),
        .not_reset   (not_reset),
        .iX          (iX),
        .iY          (iY),
        .iValue      (iValue),
        .iWren       (iWren),
        .iStart      (iStart),
        .oPixValid   (oPixValid),
        .iPixReady   (iPixReady),
        .oPixX       (oPixX),
        .oPixY       (oPixY),
        .oPixData    (oPixData),
        .oFrameLast  (oFrameLast),
        .oWriteCount (oWriteCount),
        .oOnesCount  (oOnesCount),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oOverrun    (oOverrun)
    );

    always #5 clock = ~clock;

    // Reference model: frame contents survive reset, counters do not.
    bit model_mem [N];
    int m_wr, m_ones;
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_write(input int x, input int y, input bit v);
        model_mem[(x << W) | y] = v;
        if (m_wr < N) m_wr++;
        if (v && m_ones < N) m_ones++;
    endtask

    task automatic write_px(input int x, input int y, input bit v);
        iX = H'(x); iY = W'(y); iValue = v; iWren = 1'b1;
        tick();
        iWren = 1'b0;
        model_write(x, y, v);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_wr"},   32'(oWriteCount), 32'(m_wr));
        check({tag, "_ones"}, 32'(oOnesCount),  32'(m_ones));
    endtask

    task automatic do_reset();
        iWren = 1'b0; iStart = 1'b0; iPixReady = 1'b0;
        not_reset = 1'b0;
        tick(); tick();
        not_reset = 1'b1;
        tick();
        m_wr = 0; m_ones = 0;
    endtask

    task automatic start(input bit with_write);
        iStart = 1'b1;
        if (with_write) begin
            iX = '0; iY = '0; iValue = 1'b1; iWren = 1'b1;
        end
        tick();
        iStart = 1'b0; iWren = 1'b0;
        if (with_write) model_write(0, 0, 1'b1);
    endtask

    // Consume the frame; returns early with the pixel at stop_at still presented.
    task automatic readout(input bit rand_ready, input bit hooks, input int stop_at, output int gaps);
        int g;
        gaps = 0;
        for (int idx = 0; idx < N; idx++) begin
            g = 0;
            while (oPixValid !== 1'b1 && g < 8) begin
                tick();
                g++;
            end
            gaps += g;
            if (oPixValid !== 1'b1) begin
                check("valid_timeout", 32'(oPixValid), 32'd1);
                return;
            end
            if (idx == stop_at) return;
            check("pix_x",    32'(oPixX),      32'(idx >> W));
            check("pix_y",    32'(oPixY),      32'(idx % (2 ** W)));
            check("pix_data", 32'(oPixData),   32'(model_mem[idx]));
            check("pix_last", 32'(oFrameLast), 32'(idx == N - 1));
            check("busy",     32'(oBusy),      32'd1);
            if (hooks && idx == 3) begin
                check("bp_data", 32'(oPixData), 32'd1);
                iPixReady = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    check("bp_valid", 32'(oPixValid), 32'd1);
                    check("bp_x",     32'(oPixX),     32'd0);
                    check("bp_y",     32'(oPixY),     32'd3);
                    check("bp_data",  32'(oPixData),  32'd1);
                end
            end
            if (hooks && idx == 20) begin
                iPixReady = 1'b0;
                iX = H'(10); iY = W'(10); iValue = ~model_mem[(10 << W) | 10]; iWren = 1'b1;
                tick();
                iWren = 1'b0;
                check("ovr_flag", 32'(oOverrun), 32'd1);
                check_counts("ovr_cnt");
                check("ovr_hold_valid", 32'(oPixValid), 32'd1);
                check("ovr_hold_y",     32'(oPixY),     32'd20);
            end
            if (rand_ready) begin
                iPixReady = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            iPixReady = 1'b1;
            tick();
            if (rand_ready) iPixReady = 1'b0;
            check("valid_drop", 32'(oPixValid), 32'd0);
        end
    endtask

    initial begin
        int gaps;
        int a;
        bit v;
        not_reset = 1'b0;
        iX = '0; iY = '0; iValue = 1'b0; iWren = 1'b0; iStart = 1'b0; iPixReady = 1'b0;
        do_reset();

        check("rst_valid",   32'(oPixValid),   32'd0);
        check("rst_busy",    32'(oBusy),       32'd0);
        check("rst_done",    32'(oDone),       32'd0);
        check("rst_overrun", 32'(oOverrun),    32'd0);
        check("rst_last",    32'(oFrameLast),  32'd0);
        check("rst_xy",      32'({oPixX, oPixY, oPixData}), 32'd0);
        check("rst_wr",      32'(oWriteCount), 32'd0);
        check("rst_ones",    32'(oOnesCount),  32'd0);

        // Full frame with checkerboard pattern.
        for (int x = 0; x < 2 ** H; x++)
            for (int y = 0; y < 2 ** W; y++)
                write_px(x, y, bit'((x ^ y) & 1));
        check("full_wr",   32'(oWriteCount), 32'(N));
        check("full_ones", 32'(oOnesCount),  32'(N / 2));

        // Counters saturate past a full frame.
        for (int i = 0; i < 12; i++) begin
            a = $urandom_range(0, N - 1);
            write_px(a >> W, a % (2 ** W), 1'b1);
        end
        check_counts("sat");
        check("sat_wr", 32'(oWriteCount), 32'(N));

        iPixReady = 1'b1;
        start(1'b0);
        readout(1'b0, 1'b0, -1, gaps);
        check("throughput_gaps", 32'(gaps), 32'(2 * N));
        check("done1_done",  32'(oDone),     32'd1);
        check("done1_busy",  32'(oBusy),     32'd0);
        check("done1_valid", 32'(oPixValid), 32'd0);
        check("done1_ovr",   32'(oOverrun),  32'd0);

        // DONE ignores start and rejects writes.
        iPixReady = 1'b0;
        start(1'b0);
        tick();
        check("done_start_ign",  32'(oBusy), 32'd0);
        check("done_start_done", 32'(oDone), 32'd1);
        iX = '0; iY = '0; iValue = 1'b1; iWren = 1'b1;
        tick();
        iWren = 1'b0;
        check("done_ovr", 32'(oOverrun), 32'd1);
        check_counts("done_cnt");

        do_reset();
        check("rst2_done", 32'(oDone),    32'd0);
        check("rst2_ovr",  32'(oOverrun), 32'd0);

        write_px(5, 5, 1'b1);
        write_px(5, 5, 1'b0);
        check("dup_wr",   32'(oWriteCount), 32'd2);
        check("dup_ones", 32'(oOnesCount),  32'd1);

        for (int i = 0; i < 150; i++) begin
            a = $urandom_range(0, N - 1);
            if (a == 0 || a == 3 || a == (5 << W) + 5 || a == (10 << W) + 10) a = 1;
            write_px(a >> W, a % (2 ** W), bit'($urandom_range(0, 1)));
        end
        write_px(0, 3, 1'b1);
        v = bit'($urandom_range(0, 1));
        write_px(10, 10, v);
        check_counts("mix");

        // Start and write together: the write lands before readout begins.
        start(1'b1);
        check_counts("sw_cnt");
        check("sw_ovr",  32'(oOverrun), 32'd0);
        check("sw_busy", 32'(oBusy),    32'd1);
        readout(1'b1, 1'b1, -1, gaps);
        check("done2_done", 32'(oDone),    32'd1);
        check("done2_ovr",  32'(oOverrun), 32'd1);
        check("px_10_10",   32'(model_mem[(10 << W) | 10]), 32'(v));
        check("px_5_5",     32'(model_mem[(5 << W) | 5]),   32'd0);

        // Asynchronous reset in the middle of a readout.
        do_reset();
        for (int i = 0; i < 3; i++) write_px(1, i, 1'b1);
        iPixReady = 1'b1;
        start(1'b0);
        readout(1'b0, 1'b0, 100, gaps);
        check("mid_ptr_y", 32'(oPixY), 32'(100 % (2 ** W)));
        #2;
        not_reset = 1'b0;
        #1;
        check("mid_valid", 32'(oPixValid),   32'd0);
        check("mid_busy",  32'(oBusy),       32'd0);
        check("mid_wr",    32'(oWriteCount), 32'd0);
        check("mid_ones",  32'(oOnesCount),  32'd0);
        check("mid_xy",    32'({oPixX, oPixY, oPixData, oFrameLast}), 32'd0);
        iPixReady = 1'b0;
        tick();
        not_reset = 1'b1;
        tick();
        m_wr = 0; m_ones = 0;
        write_px(2, 2, 1'b1);
        check_counts("post_rst_capture");
        check("post_rst_ovr", 32'(oOverrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
